// File: rtl/sfu_accum.sv
// sfu_accum
//
// Special-function / accumulation stage sitting behind the output FIFO.
// For every kernel-position pass it pops one psum row per output pixel and
// accumulates it lane-wise into the psum SRAM (PMEM) with a read-modify-write.
// On the first pass the rows are written directly. On the final pass, negative
// results are optionally clamped to zero (ReLU).
//
// Build option:
//   SFU_RELU_EN - when defined, passes started with `last` write negative lanes
//                 as 0. When undefined, `last` is ignored and no ReLU logic
//                 exists.
//
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   start         - one-cycle pass start, only looked at while idle
//   first, last   - pass qualifiers, captured together with start
//   base          - PMEM base address of the pass, captured with start
//   ofifo_out     - OFIFO head row (lane k = bits [k*psum_bw +: psum_bw])
//   ofifo_valid   - OFIFO head holds a complete row
//   ofifo_rd      - pop the OFIFO head at this edge
//   op_q          - PMEM read data, valid the cycle after a read
//   op_d, op_addr - PMEM write data and address
//   op_cen        - PMEM chip enable, active-low
//   op_wen        - PMEM write enable, active-low
//   busy          - a pass is in progress
//   done          - one-cycle pulse after the final row has been written
module sfu_accum #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 9,
    parameter int n_out   = 36
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     first,
    input  logic                     last,
    input  logic [addr_w-1:0]        base,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    input  logic                     ofifo_valid,
    output logic                     ofifo_rd,
    input  logic [col*psum_bw-1:0]   op_q,
    output logic [col*psum_bw-1:0]   op_d,
    output logic [addr_w-1:0]        op_addr,
    output logic                     op_cen,
    output logic                     op_wen,
    output logic                     busy,
    output logic                     done
);

    localparam int ROW_W = (n_out > 1) ? $clog2(n_out) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [addr_w-1:0]      base_q, base_d;
    logic                   first_q, first_d;
    logic [col*psum_bw-1:0] capRow_q, capRow_d;
    logic [addr_w-1:0]      addrHold_q, addrHold_d;
    logic [col*psum_bw-1:0] dataHold_q, dataHold_d;
    logic [addr_w-1:0]      curAddr;
    logic [col*psum_bw-1:0] result;

`ifdef SFU_RELU_EN
    logic                   last_q, last_d;
`else
    logic                   unusedLast;
    assign unusedLast = last;
`endif

    // Row address wraps naturally at 2^addr_w.
    assign curAddr = base_q + addr_w'(row_q);

    // Per-lane result: either the captured row (first pass) or the saturated
    // sum of stored and captured values. Overflow is detected from the top two
    // bits of the one-bit-wider sum.
    for (genvar k = 0; k < col; k++) begin : gLane
        logic [psum_bw-1:0] capLane;
        logic [psum_bw-1:0] memLane;
        logic [psum_bw:0]   sum;
        logic [psum_bw-1:0] satLane;
        logic [psum_bw-1:0] outLane;

        assign capLane = capRow_q[k*psum_bw +: psum_bw];
        assign memLane = op_q[k*psum_bw +: psum_bw];
        assign sum     = {capLane[psum_bw-1], capLane} + {memLane[psum_bw-1], memLane};

        always_comb begin
            satLane = sum[psum_bw-1:0];
            if (sum[psum_bw] != sum[psum_bw-1]) begin
                satLane = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                       : {1'b0, {(psum_bw-1){1'b1}}};
            end
        end

        always_comb begin
            outLane = first_q ? capLane : satLane;
`ifdef SFU_RELU_EN
            if (last_q && outLane[psum_bw-1]) begin
                outLane = '0;
            end
`endif
        end

        assign result[k*psum_bw +: psum_bw] = outLane;
    end

    // State and datapath registers. Address and write data have hold copies so
    // the SRAM pins keep their last values outside the active states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            base_q     <= '0;
            first_q    <= 1'b0;
            capRow_q   <= '0;
            addrHold_q <= '0;
            dataHold_q <= '0;
`ifdef SFU_RELU_EN
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            base_q     <= base_d;
            first_q    <= first_d;
            capRow_q   <= capRow_d;
            addrHold_q <= addrHold_d;
            dataHold_q <= dataHold_d;
`ifdef SFU_RELU_EN
            last_q     <= last_d;
`endif
        end
    end

    // Next-state and output decode. A row takes a FETCH (pop + optional read)
    // followed by a WRITE of the same address; FETCH stalls while the OFIFO
    // head is not valid, issuing no SRAM access.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        base_d     = base_q;
        first_d    = first_q;
        capRow_d   = capRow_q;
        addrHold_d = addrHold_q;
        dataHold_d = dataHold_q;
`ifdef SFU_RELU_EN
        last_d     = last_q;
`endif
        ofifo_rd   = 1'b0;
        op_cen     = 1'b1;
        op_wen     = 1'b1;
        op_addr    = addrHold_q;
        op_d       = dataHold_q;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    row_d   = '0;
                    base_d  = base;
                    first_d = first;
`ifdef SFU_RELU_EN
                    last_d  = last;
`endif
                end
            end
            FETCH: begin
                op_addr    = curAddr;
                addrHold_d = curAddr;
                if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    capRow_d = ofifo_out;
                    op_cen   = first_q;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                op_cen     = 1'b0;
                op_wen     = 1'b0;
                op_addr    = curAddr;
                op_d       = result;
                addrHold_d = curAddr;
                dataHold_d = result;
                if (row_q == ROW_W'(n_out - 1)) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
